mac_acc_pipe: RTL and testbench

- Pipelined, parametrised multi-mode MAC with an internal accumulator and valid/ready handshakes on both sides.
- Modes: INT4 dot product, INT8 dot product, INT4 with per-vector scale factors (INT4_VSQ).
- Accumulates a group of beats delimited by i_first/i_last and emits one saturated result per group, with a sticky saturation flag.
- Sits in the PE array between operand buffers and the output/requant stage.

---
 rtl/mac_acc_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_mac_acc_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_pipe.sv
// mac_acc_pipe: two-stage multi-mode MAC (INT4 / INT8 / INT4 with per-vector
// scale factors). Stage 1 forms a clamped dot product per beat, and stage 2
// accumulates beats into a group result with symmetric saturation and a sticky
// saturation flag. A single global enable stalls the whole pipe while a result
// is waiting on downstream.
module mac_acc_pipe #(
  parameter int unsigned DAT_W   = 64,
  parameter int unsigned SF_W    = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned INT4_VS = DAT_W / 4,
  parameter int unsigned INT8_VS = DAT_W / 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic             i_first,
  input  logic             i_last,
  input  logic [DAT_W-1:0] i_a_data,
  input  logic [DAT_W-1:0] i_b_data,
  input  logic [SF_W-1:0]  i_a_sf,
  input  logic [SF_W-1:0]  i_b_sf,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_result,
  output logic             o_sat
);

  // Mode encodings; the remaining code is reserved and contributes zero.
  localparam logic [1:0] MODE_INT4     = 2'd0;
  localparam logic [1:0] MODE_INT8     = 2'd1;
  localparam logic [1:0] MODE_INT4_VSQ = 2'd2;

  // Full-precision widths so that no intermediate result can wrap.
  localparam int unsigned DOT4_W = 8 + $clog2(INT4_VS) + 1;
  localparam int unsigned DOT8_W = 16 + $clog2(INT8_VS) + 1;
  localparam int unsigned SFP_W  = 2 * SF_W;
  localparam int unsigned VSQ_W  = DOT4_W + SFP_W + 1;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned MAX1_W = (DOT8_W > VSQ_W) ? DOT8_W : VSQ_W;
  localparam int unsigned PROD_W = (MAX1_W > SUM_W) ? MAX1_W : SUM_W;

  // Symmetric clamp limits: the most negative code is never produced.
  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = -ACC_MAX;
  localparam logic signed [PROD_W-1:0] P_MAX   = PROD_W'(ACC_MAX);
  localparam logic signed [PROD_W-1:0] P_MIN   = -P_MAX;
  localparam logic signed [SUM_W-1:0]  S_MAX   = SUM_W'(ACC_MAX);
  localparam logic signed [SUM_W-1:0]  S_MIN   = -S_MAX;

  logic en;
  logic accept;

  // Stage-1 datapath signals
  logic signed [3:0]        a4;
  logic signed [3:0]        b4;
  logic signed [7:0]        p4;
  logic signed [7:0]        a8;
  logic signed [7:0]        b8;
  logic signed [15:0]       p8;
  logic signed [DOT4_W-1:0] dot4;
  logic signed [DOT8_W-1:0] dot8;
  logic [SFP_W-1:0]         sf_prod;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [ACC_W-1:0]  prod_clip;
  logic                     prod_sat;

  // Stage-2 datapath signals
  logic signed [ACC_W-1:0]  addend;
  logic signed [ACC_W-1:0]  base;
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sum_clip;
  logic                     sum_sat;
  logic                     grp_sat_new;

  // Pipeline registers
  logic                    s1_valid_q, s1_valid_d;
  logic signed [ACC_W-1:0] s1_prod_q,  s1_prod_d;
  logic                    s1_sat_q,   s1_sat_d;
  logic [1:0]              s1_mode_q,  s1_mode_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q,  s1_last_d;
  logic signed [ACC_W-1:0] acc_q,      acc_d;
  logic                    grp_sat_q,  grp_sat_d;
  logic                    o_valid_q,  o_valid_d;
  logic signed [ACC_W-1:0] o_result_q, o_result_d;
  logic                    o_sat_q,    o_sat_d;

  // Global stall: everything advances unless a result is stuck at the output.
  assign en      = ~o_valid_q | i_ready;
  assign o_ready = en;
  assign accept  = i_valid & en;

  assign o_valid  = o_valid_q;
  assign o_result = o_result_q;
  assign o_sat    = o_sat_q;

  // Per-beat dot products, scale factor product, mode select and clamp.
  always_comb begin
    a4        = '0;
    b4        = '0;
    p4        = '0;
    a8        = '0;
    b8        = '0;
    p8        = '0;
    dot4      = '0;
    dot8      = '0;
    prod_full = '0;
    prod_clip = '0;
    prod_sat  = 1'b0;

    for (int i = 0; i < INT4_VS; i++) begin
      a4   = i_a_data[4*i +: 4];
      b4   = i_b_data[4*i +: 4];
      p4   = 8'(a4) * 8'(b4);
      dot4 = dot4 + DOT4_W'(p4);
    end

    for (int j = 0; j < INT8_VS; j++) begin
      a8   = i_a_data[8*j +: 8];
      b8   = i_b_data[8*j +: 8];
      p8   = 16'(a8) * 16'(b8);
      dot8 = dot8 + DOT8_W'(p8);
    end

    sf_prod = SFP_W'(i_a_sf) * SFP_W'(i_b_sf);

    case (i_mode)
      MODE_INT4:     prod_full = PROD_W'(dot4);
      MODE_INT8:     prod_full = PROD_W'(dot8);
      MODE_INT4_VSQ: prod_full = PROD_W'(dot4) * PROD_W'($signed({1'b0, sf_prod}));
      default:       prod_full = '0;
    endcase

    if (prod_full > P_MAX) begin
      prod_clip = ACC_MAX;
      prod_sat  = 1'b1;
    end else if (prod_full < P_MIN) begin
      prod_clip = ACC_MIN;
      prod_sat  = 1'b1;
    end else begin
      prod_clip = ACC_W'(prod_full);
    end
  end

  // Group accumulation with one guard bit, then symmetric clamp.
  always_comb begin
    addend      = (s1_mode_q == 2'd3) ? '0 : s1_prod_q;
    base        = s1_first_q ? '0 : acc_q;
    sum         = SUM_W'(base) + SUM_W'(addend);
    sum_clip    = '0;
    sum_sat     = 1'b0;
    if (sum > S_MAX) begin
      sum_clip = ACC_MAX;
      sum_sat  = 1'b1;
    end else if (sum < S_MIN) begin
      sum_clip = ACC_MIN;
      sum_sat  = 1'b1;
    end else begin
      sum_clip = ACC_W'(sum);
    end
    grp_sat_new = (s1_first_q ? 1'b0 : grp_sat_q) | s1_sat_q | sum_sat;
  end

  // Next-state for all pipeline registers; hold everything when stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_sat_d   = s1_sat_q;
    s1_mode_d  = s1_mode_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    acc_d      = acc_q;
    grp_sat_d  = grp_sat_q;
    o_valid_d  = o_valid_q;
    o_result_d = o_result_q;
    o_sat_d    = o_sat_q;

    if (en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_prod_d  = prod_clip;
        s1_sat_d   = prod_sat;
        s1_mode_d  = i_mode;
        s1_first_d = i_first;
        s1_last_d  = i_last;
      end

      o_valid_d = s1_valid_q & s1_last_q;

      if (s1_valid_q) begin
        if (s1_last_q) begin
          o_result_d = sum_clip;
          o_sat_d    = grp_sat_new;
          acc_d      = '0;
          grp_sat_d  = 1'b0;
        end else begin
          acc_d      = sum_clip;
          grp_sat_d  = grp_sat_new;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_sat_q   <= 1'b0;
      s1_mode_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      grp_sat_q  <= 1'b0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
      o_sat_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_sat_q   <= s1_sat_d;
      s1_mode_q  <= s1_mode_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      acc_q      <= acc_d;
      grp_sat_q  <= grp_sat_d;
      o_valid_q  <= o_valid_d;
      o_result_q <= o_result_d;
      o_sat_q    <= o_sat_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Bench for mac_acc_pipe: directed cases plus randomized traffic checked
// against an arithmetic group model fed from observed handshakes.
module tb_mac_acc_pipe;

  localparam int unsigned DAT_W = 64;
  localparam int unsigned SF_W  = 8;
  localparam int unsigned ACC_W = 32;
  localparam logic [1:0] M_INT4 = 2'd0;
  localparam logic [1:0] M_INT8 = 2'd1;
  localparam logic [1:0] M_VSQ  = 2'd2;
  localparam logic [1:0] M_RSV  = 2'd3;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_mode;
  logic             i_first;
  logic             i_last;
  logic [DAT_W-1:0] i_a_data;
  logic [DAT_W-1:0] i_b_data;
  logic [SF_W-1:0]  i_a_sf;
  logic [SF_W-1:0]  i_b_sf;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_result;
  logic             o_sat;

  int errors = 0;
  int checks = 0;
  int n_res  = 0;
  bit rnd_rdy = 1'b0;

  longint m_acc = 0;
  bit     m_sat = 1'b0;
  longint exp_res[$];
  bit     exp_sat[$];

  mac_acc_pipe #(.DAT_W(DAT_W), .SF_W(SF_W), .ACC_W(ACC_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_first(i_first), .i_last(i_last),
    .i_a_data(i_a_data), .i_b_data(i_b_data), .i_a_sf(i_a_sf), .i_b_sf(i_b_sf),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DAT_W-1:0] rep4(input int v);
    logic [3:0] n = 4'(v);
    return {(DAT_W/4){n}};
  endfunction

  function automatic logic [DAT_W-1:0] rep8(input int v);
    logic [7:0] n = 8'(v);
    return {(DAT_W/8){n}};
  endfunction

  function automatic longint clip(input longint v, output bit s);
    s = 1'b0;
    if (v > ACC_MAX) begin s = 1'b1; return ACC_MAX; end
    if (v < -ACC_MAX) begin s = 1'b1; return -ACC_MAX; end
    return v;
  endfunction

  // Reference: dot product of signed lanes, optional scale, clamped.
  function automatic longint ref_prod(input logic [1:0] m, input logic [DAT_W-1:0] a,
                                      input logic [DAT_W-1:0] b, input logic [SF_W-1:0] asf,
                                      input logic [SF_W-1:0] bsf, output bit s);
    longint acc = 0;
    int av;
    int bv;
    if (m == M_INT4 || m == M_VSQ) begin
      for (int i = 0; i < DAT_W/4; i++) begin
        av = $signed(a[4*i +: 4]);
        bv = $signed(b[4*i +: 4]);
        acc += longint'(av * bv);
      end
      if (m == M_VSQ) acc = acc * (longint'(asf) * longint'(bsf));
    end else if (m == M_INT8) begin
      for (int i = 0; i < DAT_W/8; i++) begin
        av = $signed(a[8*i +: 8]);
        bv = $signed(b[8*i +: 8]);
        acc += longint'(av * bv);
      end
    end
    return clip(acc, s);
  endfunction

  task automatic model_beat();
    bit ps;
    bit ss;
    longint p;
    longint s;
    p = ref_prod(i_mode, i_a_data, i_b_data, i_a_sf, i_b_sf, ps);
    s = clip((i_first ? 0 : m_acc) + p, ss);
    m_sat = (i_first ? 1'b0 : m_sat) | ps | ss;
    if (i_last) begin
      exp_res.push_back(s);
      exp_sat.push_back(m_sat);
      m_acc = 0;
      m_sat = 1'b0;
    end else begin
      m_acc = s;
    end
  endtask

  // Observe handshakes away from the clock edge and score results in order.
  always @(negedge i_clk) begin
    if (i_rst) begin
      m_acc = 0;
      m_sat = 1'b0;
      exp_res.delete();
      exp_sat.delete();
    end else begin
      if (o_valid && i_ready) begin
        n_res++;
        check_eq("mon_pending", longint'(exp_res.size() > 0), 1);
        if (exp_res.size() > 0) begin
          check_eq("mon_res", longint'($signed(o_result)), exp_res.pop_front());
          check_eq("mon_sat", longint'(o_sat), longint'(exp_sat.pop_front()));
        end
      end
      if (i_valid && o_ready) model_beat();
    end
  end

  task automatic send_beat(input logic [1:0] m, input logic [DAT_W-1:0] a,
                           input logic [DAT_W-1:0] b, input int asf, input int bsf,
                           input bit f, input bit l);
    bit ok;
    int n = 0;
    i_valid  = 1'b1;
    i_mode   = m;
    i_a_data = a;
    i_b_data = b;
    i_a_sf   = 8'(asf);
    i_b_sf   = 8'(bsf);
    i_first  = f;
    i_last   = l;
    do begin
      @(negedge i_clk);
      ok = o_ready;
      @(posedge i_clk);
      #1;
      n++;
      if (!ok && rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
    end while (!ok && n < 1000);
    if (!ok) check_eq("send_timeout", longint'(ok), 1);
    i_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input longint er, input bit es);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(o_valid && i_ready) && n < 200);
    check_eq({tag, "_vld"}, longint'(o_valid), 1);
    check_eq({tag, "_res"}, longint'($signed(o_result)), er);
    check_eq({tag, "_sat"}, longint'(o_sat), longint'(es));
    @(posedge i_clk);
    #1;
  endtask

  task automatic vsq_group(input int nb, input int av, input int bv);
    for (int k = 0; k < nb; k++)
      send_beat(M_VSQ, rep4(av), rep4(bv), 255, 255, k == 0, k == nb - 1);
  endtask

  initial begin
    int n0;
    i_rst = 1'b1; i_valid = 1'b0; i_mode = M_INT4; i_first = 1'b0; i_last = 1'b0;
    i_a_data = '0; i_b_data = '0; i_a_sf = '0; i_b_sf = '0; i_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge i_clk);
    check_eq("rst_valid", longint'(o_valid), 0);
    check_eq("rst_result", longint'($signed(o_result)), 0);
    check_eq("rst_sat", longint'(o_sat), 0);
    check_eq("rst_ready", longint'(o_ready), 1);
    @(posedge i_clk); #1; i_rst = 1'b0;

    // Test 1: INT4 single beat and two-cycle latency
    send_beat(M_INT4, rep4(1), rep4(1), 0, 0, 1, 1);
    check_eq("t1_lat1_valid", longint'(o_valid), 0);
    @(posedge i_clk); #1;
    check_eq("t1_lat2_valid", longint'(o_valid), 1);
    check_eq("t1_res", longint'($signed(o_result)), 16);
    check_eq("t1_sat", longint'(o_sat), 0);
    repeat (2) @(posedge i_clk); #1;

    // Test 2: INT8 three-beat group at the negative extreme
    for (int k = 0; k < 3; k++) send_beat(M_INT8, rep8(-128), rep8(-128), 0, 0, k == 0, k == 2);
    wait_result("t2", 393216, 0);

    // Test 3: scaled INT4
    send_beat(M_VSQ, rep4(1), rep4(1), 2, 3, 1, 1);
    wait_result("t3a", 96, 0);
    send_beat(M_VSQ, rep4(-8), rep4(1), 1, 1, 1, 1);
    wait_result("t3b", -128, 0);

    // Test 4: saturation boundary, recovery, and symmetric negative clamp
    vsq_group(32, -8, -8);
    wait_result("t4_32", 2130739200, 0);
    vsq_group(33, -8, -8);
    wait_result("t4_33", ACC_MAX, 1);
    send_beat(M_INT4, rep4(1), rep4(1), 0, 0, 1, 1);
    wait_result("t4_next", 16, 0);
    vsq_group(36, -8, 7);
    wait_result("t4_neg36", -2097446400, 0);
    vsq_group(37, -8, 7);
    wait_result("t4_neg37", -ACC_MAX, 1);

    // Reserved mode contributes nothing
    send_beat(M_INT4, rep4(1), rep4(1), 0, 0, 1, 0);
    send_beat(M_RSV, rep4(7), rep4(7), 9, 9, 0, 1);
    wait_result("rsv", 16, 0);

    // Test 5: backpressure holds the whole pipe
    i_ready = 1'b0;
    send_beat(M_INT4, rep4(1), rep4(2), 0, 0, 1, 1);
    send_beat(M_INT4, rep4(1), rep4(3), 0, 0, 1, 1);
    i_valid = 1'b1; i_a_data = rep4(1); i_b_data = rep4(4);
    n0 = n_res;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check_eq("t5_ready", longint'(o_ready), 0);
      check_eq("t5_valid", longint'(o_valid), 1);
      check_eq("t5_hold", longint'($signed(o_result)), 32);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    send_beat(M_INT4, rep4(1), rep4(4), 0, 0, 1, 1);
    repeat (6) @(posedge i_clk); #1;
    check_eq("t5_count", longint'(n_res - n0), 3);

    // Test 6: reset in the middle of a group
    send_beat(M_INT8, rep8(100), rep8(100), 0, 0, 1, 0);
    send_beat(M_INT8, rep8(100), rep8(100), 0, 0, 0, 0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check_eq("t6_rst_valid", longint'(o_valid), 0);
    check_eq("t6_rst_ready", longint'(o_ready), 1);
    @(posedge i_clk); #1; i_rst = 1'b0;
    send_beat(M_INT8, rep8(3), rep8(5), 0, 0, 1, 1);
    wait_result("t6", 120, 0);

    // Randomized traffic with random downstream stalls
    rnd_rdy = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic [1:0] m;
      logic [DAT_W-1:0] a;
      logic [DAT_W-1:0] b;
      m = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin a = rep4(-8); b = rep4(-8); end
      if ($urandom_range(0, 4) == 0) begin
        i_ready = $urandom_range(0, 1) != 0;
        @(posedge i_clk); #1;
      end
      i_ready = ($urandom_range(0, 3) != 0);
      send_beat(m, a, b, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    rnd_rdy = 1'b0;
    i_ready = 1'b1;
    send_beat(M_INT8, rep8(1), rep8(1), 0, 0, 0, 1);
    repeat (10) @(posedge i_clk); #1;
    check_eq("drain_q", longint'(exp_res.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
